wide_add_sequencer: RTL and testbench

//   Upstream/downstream controller for the pipelined 4-bit carry-select adder.
//   - Accepts one WIDTH-bit add request (A, B, Cin) on a valid/ready handshake.
//   - Issues it to the adder one nibble per cycle, LSB nibble first.
//   - Feeds the adder's registered carry-out back in as the next nibble's carry-in.
//   - Gathers the returned nibbles into a WIDTH-bit result, presented on a valid/ready handshake.

---
 rtl/wide_add_pkg.sv | 16 +
 rtl/wide_add_sequencer.sv | 179 +++++++++++++++++
 tb/tb_wide_add_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// Shared constants and state encoding for the wide add sequencer.
package wide_add_pkg;

    // Width of one adder slice.
    localparam int NIBBLE_W  = 4;

    // Cycles from issuing a nibble to the adder until its sum can be captured.
    localparam int ADDER_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/wide_add_sequencer.sv
// Sequences a WIDTH-bit add through an external pipelined 4-bit adder,
// one nibble per cycle, LSB first, chaining the adder's registered carry.
// Optional feature macro: WIDE_ADD_OVF_EN adds the registered out_ovf port.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_sum,
    output logic                out_cout,
`ifdef WIDE_ADD_OVF_EN
    output logic                out_ovf,
`endif
    output logic [NIBBLE_W-1:0] adder_a,
    output logic [NIBBLE_W-1:0] adder_b,
    output logic                adder_cin,
    input  logic [NIBBLE_W-1:0] adder_sum,
    input  logic                adder_cout
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(N);
    localparam int CW    = IDX_W + 1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_q_reg, b_q_reg;
    logic               cin_q_reg;
    logic [CW-1:0]      issue_cnt_reg;   // cycles spent in RUN
    logic [CW-1:0]      cap_cnt_reg;     // index of the next nibble to capture
    logic [WIDTH-1:0]   out_sum_reg;
    logic               out_cout_reg;

    logic [NIBBLE_W-1:0] a_nib [N];
    logic [NIBBLE_W-1:0] b_nib [N];
    logic [NIBBLE_W-1:0] acc_reg [N-1];
    logic [WIDTH-NIBBLE_W-1:0] acc_flat;

    logic issue_en, compute_en, capture_en, last_capture;
    logic accept;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_nib
            assign a_nib[gi] = a_q_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi] = b_q_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
        // Lower nibbles wait here until the top nibble arrives, so out_sum changes in one edge.
        for (gi = 0; gi < N-1; gi++) begin : g_acc
            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_reg[gi] <= '0;
                end else if (capture_en && cap_cnt_reg == CW'(gi)) begin
                    acc_reg[gi] <= adder_sum;
                end
            end
            assign acc_flat[gi*NIBBLE_W +: NIBBLE_W] = acc_reg[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, handshakes and the issue/compute/capture windows.
    always_comb begin
        state_next   = state_reg;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        issue_en     = 1'b0;
        compute_en   = 1'b0;
        capture_en   = 1'b0;
        last_capture = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                issue_en     = (issue_cnt_reg < CW'(N));
                compute_en   = (issue_cnt_reg >= CW'(ADDER_LAT - 1)) &&
                               (issue_cnt_reg <= CW'(N + ADDER_LAT - 2));
                capture_en   = (issue_cnt_reg >= CW'(ADDER_LAT));
                last_capture = capture_en && (cap_cnt_reg == CW'(N - 1));
                if (last_capture) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_ready && in_valid;

    // Adder drive: operands in the issue window, chained carry in the compute window, else zero.
    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        if (issue_en) begin
            adder_a = a_nib[issue_cnt_reg[IDX_W-1:0]];
            adder_b = b_nib[issue_cnt_reg[IDX_W-1:0]];
        end
        if (compute_en) begin
            adder_cin = (issue_cnt_reg == CW'(ADDER_LAT - 1)) ? cin_q_reg : adder_cout;
        end
    end

    // Operand latch, counters and the final result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q_reg       <= '0;
            b_q_reg       <= '0;
            cin_q_reg     <= 1'b0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            out_sum_reg   <= '0;
            out_cout_reg  <= 1'b0;
        end else begin
            if (accept) begin
                a_q_reg       <= in_a;
                b_q_reg       <= in_b;
                cin_q_reg     <= in_cin;
                issue_cnt_reg <= '0;
                cap_cnt_reg   <= '0;
            end else if (state_reg == RUN && !last_capture) begin
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
                if (capture_en) begin
                    cap_cnt_reg <= cap_cnt_reg + 1'b1;
                end
            end
            if (last_capture) begin
                out_sum_reg  <= {adder_sum, acc_flat};
                out_cout_reg <= adder_cout;
            end
        end
    end

    assign out_sum  = out_sum_reg;
    assign out_cout = out_cout_reg;

`ifdef WIDE_ADD_OVF_EN
    logic out_ovf_reg;

    // Signed overflow: like-signed operands producing a result of the other sign.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_ovf_reg <= 1'b0;
        end else if (last_capture) begin
            out_ovf_reg <= (a_q_reg[WIDTH-1] == b_q_reg[WIDTH-1]) &&
                           (adder_sum[NIBBLE_W-1] != a_q_reg[WIDTH-1]);
        end
    end

    assign out_ovf = out_ovf_reg;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WIDTH=16) with a behavioural
// pipelined 4-bit adder beside it. Build with WIDE_ADD_OVF_EN to also check out_ovf.
module tb_wide_add_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
`ifdef WIDE_ADD_OVF_EN
    logic        out_ovf;
`endif
    logic [3:0]  adder_a, adder_b, adder_sum;
    logic        adder_cin, adder_cout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
`ifdef WIDE_ADD_OVF_EN
        .out_ovf    (out_ovf),
`endif
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout)
    );

    // Pipelined 4-bit adder: operands registered, then sum/carry registered
    // using the carry-in presented during the compute cycle. reset_n = ~reset.
    logic [3:0] add_a_r, add_b_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            add_a_r    <= '0;
            add_b_r    <= '0;
            adder_sum  <= '0;
            adder_cout <= 1'b0;
        end else begin
            add_a_r <= adder_a;
            add_b_r <= adder_b;
            {adder_cout, adder_sum} <= {1'b0, add_a_r} + {1'b0, add_b_r} + {4'b0, adder_cin};
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One full transaction: accept, wait for the result, hold it for 'stall' cycles, consume it.
    task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int stall,
                          output logic [15:0] sum, output logic cout, output logic ovf,
                          output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        sum  = out_sum;
        cout = out_cout;
`ifdef WIDE_ADD_OVF_EN
        ovf  = out_ovf;
`else
        ovf  = 1'b0;
`endif
        check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_sum", {16'b0, out_sum}, {16'b0, sum});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_out", {31'b0, in_ready}, 32'd1);
        check("valid_after_out", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                             input logic exp_ovf, input int stall);
        logic [15:0] s;
        logic        c, o;
        int          lat;
        do_txn(a, b, cin, stall, s, c, o, lat);
        $display("[TB] txn %s a=%h b=%h cin=%b sum=%h cout=%b ovf=%b lat=%0d (exp %h %b %b)",
                 tag, a, b, cin, s, c, o, lat, exp_sum, exp_cout, exp_ovf);
        check({tag, "_sum"}, {16'b0, s}, {16'b0, exp_sum});
        check({tag, "_cout"}, {31'b0, c}, {31'b0, exp_cout});
        check({tag, "_latency"}, 32'(lat), 32'd7);
`ifdef WIDE_ADD_OVF_EN
        check({tag, "_ovf"}, {31'b0, o}, {31'b0, exp_ovf});
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, hold_sum;
        logic        rc, hold_cout;
        logic [16:0] full;
        logic        rovf;
        int          guard;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[8] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_sum", {16'b0, out_sum}, 32'd0);
        check("reset_out_cout", {31'b0, out_cout}, 32'd0);
        check("idle_adder_drive", {23'b0, adder_a, adder_b, adder_cin}, 32'd0);

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                      tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0);
        end

        // Result held with out_ready low; in_valid pulses must be ignored.
        in_a = 16'h0F0F; in_b = 16'h00F1; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("stall_reached_valid", {31'b0, out_valid}, 32'd1);
        hold_sum  = out_sum;
        hold_cout = out_cout;
        check("stall_first_sum", {16'b0, hold_sum}, 32'h1000);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_a     = 16'(($urandom));
            in_b     = 16'(($urandom));
            @(posedge clk); #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_sum", {16'b0, out_sum}, {16'b0, hold_sum});
            check("hold_cout", {31'b0, out_cout}, {31'b0, hold_cout});
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_out_valid", {31'b0, out_valid}, 32'd0);
        check("release_sum_kept", {16'b0, out_sum}, {16'b0, hold_sum});
        $display("[TB] txn stall sum=%h cout=%b in_ready=%b", hold_sum, hold_cout, in_ready);

        // Reset three cycles after accept, with a carry-heavy add in flight.
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midrun_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_out_sum", {16'b0, out_sum}, 32'd0);
        $display("[TB] txn midreset in_ready=%b out_valid=%b out_sum=%h", in_ready, out_valid, out_sum);
        run_check("post_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        // Random operands against plain arithmetic.
        for (int i = 0; i < 30; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_check($sformatf("rand%0d", i), ra, rb, rc, full[15:0], full[16], rovf,
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
